// File: rtl/img_pkg.sv
// img_pkg: frame-buffer geometry, pixel type and writer states shared by camera writer and display reader
package img_pkg;
  localparam int IMG_W  = 320;
  localparam int IMG_H  = 240;
  localparam int ADDR_W = $clog2(IMG_W * IMG_H);
  localparam int X_W    = $clog2(IMG_W + 1);
  localparam int Y_W    = $clog2(IMG_H + 1);
  typedef logic [15:0] rgb565_t;
  typedef enum logic [1:0] {IDLE, WAIT_VS, ACTIVE} wr_state_e;
endpackage

// File: rtl/cam_sync.sv
// cam_sync: synchronizes the DVP pins into clk and produces registered edge pulses
//  ports: clk, reset_n (async, active low); pclk/vsync/href/data raw camera pins;
//  pclk_rise, vsync_rise, vsync_fall, href_fall one-clk pulses; href_s/data_s aligned with the pulses
module cam_sync #(
  parameter int STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pclk,
  input  logic       vsync,
  input  logic       href,
  input  logic [7:0] data,
  output logic       pclk_rise,
  output logic       vsync_rise,
  output logic       vsync_fall,
  output logic       href_fall,
  output logic       href_s,
  output logic [7:0] data_s
);
  logic [10:0] sr [STAGES];
  logic [10:0] last;
  logic [2:0]  prev;
  assign last = sr[STAGES-1];
  // pulses and the href/data sample are registered together so they stay cycle-aligned
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) sr[i] <= '0;
      prev       <= '0;
      pclk_rise  <= 1'b0;
      vsync_rise <= 1'b0;
      vsync_fall <= 1'b0;
      href_fall  <= 1'b0;
      href_s     <= 1'b0;
      data_s     <= '0;
    end else begin
      sr[0] <= {pclk, vsync, href, data};
      for (int i = 1; i < STAGES; i++) sr[i] <= sr[i-1];
      prev       <= last[10:8];
      pclk_rise  <= last[10] & ~prev[2];
      vsync_rise <= last[9] & ~prev[1];
      vsync_fall <= ~last[9] & prev[1];
      href_fall  <= ~last[8] & prev[0];
      href_s     <= last[8];
      data_s     <= last[7:0];
    end
endmodule

// File: rtl/img_mem_writer.sv
// img_mem_writer: pairs DVP bytes into RGB565 pixels and writes them to the frame BRAM at y*IMG_W+x
//  ports: clk, reset_n (async, active low); cam_pclk/vsync/href/data camera pins; capture_en frame-level enable;
//  we/wAddr/wData BRAM write port; frame_done pulse; frame_cnt captured frames; sync_err sticky odd-byte flag
module img_mem_writer
  import img_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cam_pclk,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  input  logic              capture_en,
  output logic              we,
  output logic [ADDR_W-1:0] wAddr,
  output rgb565_t           wData,
  output logic              frame_done,
  output logic [7:0]        frame_cnt,
  output logic              sync_err
);
  localparam logic [X_W-1:0]    XM      = X_W'(IMG_W);
  localparam logic [Y_W-1:0]    YM      = Y_W'(IMG_H);
  localparam logic [Y_W-1:0]    YL      = Y_W'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] LB_STEP = ADDR_W'(IMG_W);
  logic              pclk_rise, vsync_rise, vsync_fall, href_fall, href_s;
  logic [7:0]        data_s, hi;
  wr_state_e         state, next_state;
  logic              start, fin, clr, pix, eol, phase;
  logic [X_W-1:0]    x;
  logic [Y_W-1:0]    y;
  logic [ADDR_W-1:0] line_base;
  cam_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .pclk       (cam_pclk),
    .vsync      (cam_vsync),
    .href       (cam_href),
    .data       (cam_data),
    .pclk_rise  (pclk_rise),
    .vsync_rise (vsync_rise),
    .vsync_fall (vsync_fall),
    .href_fall  (href_fall),
    .href_s     (href_s),
    .data_s     (data_s)
  );
  assign pix = (state == ACTIVE) && href_s && pclk_rise;
  assign eol = (state == ACTIVE) && href_fall;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= next_state;
  always_comb begin
    clr        = (state == IDLE) && capture_en;
    start      = (state == WAIT_VS) && vsync_fall;
    fin        = (state == ACTIVE) && vsync_rise;
    next_state = clr ? WAIT_VS : start ? ACTIVE : fin ? (capture_en ? WAIT_VS : IDLE) : state;
  end
  // pix and eol never coincide: href_s is already low in the href_fall cycle
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      phase      <= 1'b0;
      hi         <= '0;
      x          <= '0;
      y          <= '0;
      line_base  <= '0;
      we         <= 1'b0;
      wAddr      <= '0;
      wData      <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      sync_err   <= 1'b0;
    end else begin
      we         <= 1'b0;
      frame_done <= fin;
      if (fin) frame_cnt <= frame_cnt + 1'b1;
      if (clr) sync_err <= 1'b0;
      if (start) begin
        phase     <= 1'b0;
        x         <= '0;
        y         <= '0;
        line_base <= '0;
      end
      if (pix && !phase) begin
        hi    <= data_s;
        phase <= 1'b1;
      end
      if (pix && phase) begin
        phase <= 1'b0;
        if (x < XM) x <= x + 1'b1;
        if (x < XM && y < YM) begin
          we    <= 1'b1;
          wAddr <= line_base + ADDR_W'(x);
          wData <= {hi, data_s};
        end
      end
      if (eol) begin
        phase <= 1'b0;
        if (phase) sync_err <= 1'b1;
        if (x != '0) begin
          x <= '0;
          if (y < YM) y <= y + 1'b1;
          // stop at the last stored line so line_base + x never leaves the buffer
          if (y < YL) line_base <= line_base + LB_STEP;
        end
      end
    end
endmodule

// File: tb/tb_img_mem_writer.sv
// tb_img_mem_writer: directed DVP frames with random pixel data checked against a geometric model
module tb_img_mem_writer;
  import img_pkg::*;
  logic              clk = 1'b0, reset_n = 1'b0;
  logic              cam_pclk = 1'b0, cam_vsync = 1'b1, cam_href = 1'b0, capture_en = 1'b0;
  logic [7:0]        cam_data = '0;
  logic              we, frame_done, sync_err;
  logic [ADDR_W-1:0] wAddr;
  logic [15:0]       wData;
  logic [7:0]        frame_cnt;
  int                checks = 0, errors = 0, fd_cnt = 0, fd_exp = 0, cnt_exp = 0;
  logic [32:0]       got_q[$], exp_q[$];
  bit                m_cap = 0, m_armed = 0, m_ph = 0;
  int                m_x = 0, m_y = 0;
  logic [7:0]        m_hi = '0;

  always #5 clk = ~clk;

  img_mem_writer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cam_pclk   (cam_pclk),
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_data   (cam_data),
    .capture_en (capture_en),
    .we         (we),
    .wAddr      (wAddr),
    .wData      (wData),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .sync_err   (sync_err)
  );

  always @(negedge clk) begin
    if (we) got_q.push_back({wAddr, wData});
    if (frame_done) fd_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // model: a complete pixel lands at y*IMG_W+x when the frame is captured and it lies inside the image
  task automatic send_byte(input logic [7:0] b);
    cam_data = b;
    cam_pclk = 1'b0;
    repeat (2) @(negedge clk);
    cam_pclk = 1'b1;
    repeat (2) @(negedge clk);
    if (!m_ph) m_hi = b;
    else begin
      if (m_cap && m_x < IMG_W && m_y < IMG_H) exp_q.push_back({ADDR_W'(m_y * IMG_W + m_x), m_hi, b});
      m_x++;
    end
    m_ph = !m_ph;
  endtask

  task automatic bytes(input int n);
    for (int i = 0; i < n; i++) send_byte(8'($urandom));
  endtask

  task automatic line_begin();
    cam_href = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic line_end();
    cam_href = 1'b0;
    repeat (6) @(negedge clk);
    if (m_x > 0) m_y++;
    m_x = 0;
    m_ph = 0;
  endtask

  task automatic line(input int n);
    line_begin();
    bytes(n);
    line_end();
  endtask

  task automatic vs_fall();
    cam_vsync = 1'b0;
    m_cap = m_armed;
    m_x = 0;
    m_y = 0;
    m_ph = 0;
    repeat (8) @(negedge clk);
  endtask

  task automatic vs_rise();
    cam_vsync = 1'b1;
    repeat (8) @(negedge clk);
    if (m_cap) begin
      fd_exp++;
      cnt_exp = (cnt_exp + 1) % 256;
      m_armed = capture_en;
    end
    m_cap = 0;
  endtask

  task automatic set_cap(input bit v);
    capture_en = v;
    if (v) m_armed = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_writes(input string tag);
    int e0;
    e0 = errors;
    repeat (4) @(negedge clk);
    chk({tag, " count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size() && errors - e0 < 4; i++)
      chk($sformatf("%s[%0d]", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic frame_checks(input string tag);
    chk({tag, " frame_done"}, fd_cnt, fd_exp);
    chk({tag, " frame_cnt"}, frame_cnt, cnt_exp);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst we", we, 0);
    chk("rst wAddr", wAddr, 0);
    chk("rst wData", wData, 0);
    chk("rst frame_done", frame_done, 0);
    chk("rst frame_cnt", frame_cnt, 0);
    chk("rst sync_err", sync_err, 0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // single pixel F81F: write exactly SYNC_STAGES+2 clk after the low-byte pclk edge
    set_cap(1);
    vs_fall();
    line_begin();
    send_byte(8'hF8);
    cam_data = 8'h1F;
    cam_pclk = 1'b0;
    repeat (2) @(negedge clk);
    cam_pclk = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k < 4) chk($sformatf("t2 we early %0d", k), we, 0);
    end
    chk("t2 we", we, 1);
    chk("t2 wAddr", wAddr, 0);
    chk("t2 wData", wData, 16'hF81F);
    exp_q.push_back({17'd0, 16'hF81F});
    m_x++;
    m_ph = 0;
    line_end();
    vs_rise();
    check_writes("t2");
    frame_checks("t2");

    // overlong line, empty line, then a short line
    vs_fall();
    line(660);
    line(0);
    line(10);
    chk("t3 line1 addr", got_q[320][32:16], 320);
    vs_rise();
    chk("t3 sync_err", sync_err, 0);
    check_writes("t3");
    frame_checks("t3");

    // odd byte count, then capture_en dropped mid-frame
    vs_fall();
    line(641);
    chk("t4 sync_err set", sync_err, 1);
    line(20);
    set_cap(0);
    vs_rise();
    chk("t4 sync_err sticky", sync_err, 1);
    check_writes("t4");
    frame_checks("t4");

    // capture_en raised mid-frame: nothing until the next vsync_fall
    vs_fall();
    line(40);
    set_cap(1);
    chk("t5 sync_err cleared", sync_err, 0);
    line(40);
    vs_rise();
    check_writes("t5 partial");
    frame_checks("t5 partial");
    vs_fall();
    line(30);
    line(30);
    vs_rise();
    chk("t5 first addr", got_q[0][32:16], 0);
    check_writes("t5");
    frame_checks("t5");

    // asynchronous reset mid-line
    vs_fall();
    line_begin();
    bytes(12);
    check_writes("t6 pre");
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t6 rst we", we, 0);
    chk("t6 rst wAddr", wAddr, 0);
    chk("t6 rst wData", wData, 0);
    chk("t6 rst frame_done", frame_done, 0);
    chk("t6 rst frame_cnt", frame_cnt, 0);
    chk("t6 rst sync_err", sync_err, 0);
    m_cap = 0;
    m_armed = capture_en;
    cnt_exp = 0;
    m_x = 0;
    m_ph = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    bytes(12);
    line_end();
    line(8);
    vs_rise();
    check_writes("t6 post");
    frame_checks("t6 post");

    // 260 lines: the last stored line is full, extra lines are dropped
    vs_fall();
    for (int i = 0; i < IMG_H - 1; i++) line(2 * $urandom_range(1, 3));
    line(2 * IMG_W);
    for (int i = 0; i < 20; i++) line(4);
    vs_rise();
    chk("t6 first addr", got_q[0][32:16], 0);
    chk("t6 last addr", got_q[got_q.size()-1][32:16], IMG_W * IMG_H - 1);
    check_writes("t6 frame");
    frame_checks("t6 frame");
    chk("t6 sync_err", sync_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
